// File: rtl/timer_share_pkg.sv
// Shared types and the round-robin selector for the timer-sharing scheduler.
// rr_pick is written for up to RR_MAX requesters so that any NREQ can reuse it.
package timer_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 26;
  localparam int RR_MAX   = 32;
  localparam int RR_IW    = 5;

  typedef enum logic {IDLE, COUNT} ts_state_t;

  typedef struct packed {
    logic             valid;
    logic [RR_IW-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0], searching upward from ptr and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int unsigned       ptr,
                                       input int unsigned       n);
    rr_pick_t         r;
    int unsigned      s;
    logic [RR_IW-1:0] j;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      s = ptr + k;
      if (s >= n) s = s - n;
      j = RR_IW'(s);
      if (k < n && !r.valid && req[j]) begin
        r.valid = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_share_scheduler_if.sv
// Request/response bundle between the game-logic FSMs and the shared timer.
interface timer_share_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 26
);
  logic                     pause;
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0][DW-1:0]  delay;
  logic [NREQ-1:0]          grant;
  logic [NREQ-1:0]          done;
  logic                     busy;
  logic [DW-1:0]            remaining;

  modport master (output pause, req, delay, input grant, done, busy, remaining);
  modport slave  (input pause, req, delay, output grant, done, busy, remaining);
endinterface

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at zero; load wins over enable.
module load_down_counter #(
  parameter int DW = 26
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] value,
  output logic [DW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  always_ff @(posedge CLOCK_50) begin
    if (reset)           count <= '0;
    else if (load)       count <= value;
    else if (en && !zero) count <= count - DW'(1);
  end

endmodule

// File: rtl/timer_share_scheduler.sv
// Round-robin owner of a single shared down-counter; pulses done to the owner on expiry.
// Each service ends in IDLE, so grants are never back to back.
module timer_share_scheduler
  import timer_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  timer_share_scheduler_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  ts_state_t       state, state_n;
  logic [NREQ-1:0] grant_q, grant_n;
  logic [NREQ-1:0] done_q, done_n;
  logic            busy_q, busy_n;
  logic [IW-1:0]   owner_q, owner_n;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_n;
  logic [IW-1:0]   owner_inc;

  logic            cnt_load, cnt_en, cnt_zero;
  logic [DW-1:0]   cnt_value, count;

  rr_pick_t        pick;
  logic [IW-1:0]   pick_idx;

  assign pick      = rr_pick(RR_MAX'(bus.req), 32'(rr_ptr_q), NREQ);
  assign pick_idx  = IW'(pick.idx);
  assign owner_inc = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    done_n    = '0;
    busy_n    = busy_q;
    owner_n   = owner_q;
    rr_ptr_n  = rr_ptr_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_value = '0;
    case (state)
      IDLE: begin
        if (!bus.pause && pick.valid) begin
          owner_n           = pick_idx;
          grant_n           = '0;
          grant_n[pick_idx] = 1'b1;
          busy_n            = 1'b1;
          cnt_load          = 1'b1;
          cnt_value         = bus.delay[pick_idx];
          state_n           = COUNT;
        end
      end
      COUNT: begin
        // Exits reload the counter with 0 so remaining reads 0 while idle.
        if (!bus.req[owner_q]) begin
          grant_n  = '0;
          busy_n   = 1'b0;
          cnt_load = 1'b1;
          rr_ptr_n = owner_inc;
          state_n  = IDLE;
        end else if (!bus.pause) begin
          if (cnt_zero) begin
            done_n          = '0;
            done_n[owner_q] = 1'b1;
            grant_n         = '0;
            busy_n          = 1'b0;
            cnt_load        = 1'b1;
            rr_ptr_n        = owner_inc;
            state_n         = IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state    <= state_n;
      grant_q  <= grant_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
      owner_q  <= owner_n;
      rr_ptr_q <= rr_ptr_n;
    end
  end

  load_down_counter #(.DW(DW)) u_cnt (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .value    (cnt_value),
    .count    (count),
    .zero     (cnt_zero)
  );

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.remaining = count;

endmodule

// File: tb/tb_timer_share_scheduler.sv
// Directed bench for timer_share_scheduler; each scenario carries a per-cycle table of expected outputs.
module tb_timer_share_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 26;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  timer_share_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus();

  timer_share_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
    int         r;
  } exp_t;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.pause = 1'b0; bus.req = '0; bus.delay = '0;
    tick(); tick();
    checks++;
    if ({bus.grant, bus.done, bus.busy} !== 9'b0 || bus.remaining !== '0) begin
      errors++;
      $display("FAIL reset: got g=%b d=%b b=%b r=%0d want all zero",
               bus.grant, bus.done, bus.busy, bus.remaining);
    end
  endtask

  task automatic test_basic();
    exp_t ex[6];
    ex = '{'{4'b0001,4'b0000,1'b1,3}, '{4'b0001,4'b0000,1'b1,2}, '{4'b0001,4'b0000,1'b1,1},
           '{4'b0001,4'b0000,1'b1,0}, '{4'b0000,4'b0001,1'b0,0}, '{4'b0000,4'b0000,1'b0,0}};
    reset = 1'b0; bus.req = 4'b0001; bus.delay[0] = DW'(3);
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({bus.grant, bus.done, bus.busy} !== {ex[c].g, ex[c].d, ex[c].b} || bus.remaining !== DW'(ex[c].r)) begin
        errors++;
        $display("FAIL basic c%0d: got g=%b d=%b b=%b r=%0d want g=%b d=%b b=%b r=%0d", c,
                 bus.grant, bus.done, bus.busy, bus.remaining, ex[c].g, ex[c].d, ex[c].b, ex[c].r);
      end
      if (c == 0) bus.delay[0] = DW'(7);
      if (c == 4) bus.req = '0;
    end
  endtask

  task automatic test_zero_delay();
    exp_t ex[3];
    ex = '{'{4'b0100,4'b0000,1'b1,0}, '{4'b0000,4'b0100,1'b0,0}, '{4'b0000,4'b0000,1'b0,0}};
    bus.req = 4'b0100; bus.delay[2] = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.grant, bus.done, bus.busy} !== {ex[c].g, ex[c].d, ex[c].b} || bus.remaining !== DW'(ex[c].r)) begin
        errors++;
        $display("FAIL zero_delay c%0d: got g=%b d=%b b=%b r=%0d want g=%b d=%b b=%b r=%0d", c,
                 bus.grant, bus.done, bus.busy, bus.remaining, ex[c].g, ex[c].d, ex[c].b, ex[c].r);
      end
      if (c == 1) bus.req = '0;
    end
  endtask

  // Pointer enters at 3, so requester 0 wins first, then 2, then 0 again.
  task automatic test_round_robin();
    exp_t ex[15];
    ex = '{'{4'b0001,4'b0000,1'b1,1}, '{4'b0001,4'b0000,1'b1,0}, '{4'b0000,4'b0001,1'b0,0},
           '{4'b0100,4'b0000,1'b1,1}, '{4'b0100,4'b0000,1'b1,0}, '{4'b0000,4'b0100,1'b0,0},
           '{4'b0001,4'b0000,1'b1,1}, '{4'b0001,4'b0000,1'b1,0}, '{4'b0000,4'b0001,1'b0,0},
           '{4'b0010,4'b0000,1'b1,1}, '{4'b0010,4'b0000,1'b1,0}, '{4'b0000,4'b0010,1'b0,0},
           '{4'b0100,4'b0000,1'b1,1}, '{4'b0000,4'b0000,1'b0,0}, '{4'b0000,4'b0000,1'b0,0}};
    for (int i = 0; i < NREQ; i++) bus.delay[i] = DW'(1);
    bus.req = 4'b0101;
    for (int c = 0; c < 15; c++) begin
      tick();
      checks++;
      if ({bus.grant, bus.done, bus.busy} !== {ex[c].g, ex[c].d, ex[c].b} || bus.remaining !== DW'(ex[c].r)) begin
        errors++;
        $display("FAIL round_robin c%0d: got g=%b d=%b b=%b r=%0d want g=%b d=%b b=%b r=%0d", c,
                 bus.grant, bus.done, bus.busy, bus.remaining, ex[c].g, ex[c].d, ex[c].b, ex[c].r);
      end
      if (c == 8)  bus.req = 4'b0111;
      if (c == 12) bus.req = '0;
    end
  endtask

  // Mid-count freeze, then pause in IDLE, then an abort while paused.
  task automatic test_pause();
    exp_t ex[16];
    ex = '{'{4'b0010,4'b0000,1'b1,5}, '{4'b0010,4'b0000,1'b1,4}, '{4'b0010,4'b0000,1'b1,3},
           '{4'b0010,4'b0000,1'b1,3}, '{4'b0010,4'b0000,1'b1,3}, '{4'b0010,4'b0000,1'b1,3},
           '{4'b0010,4'b0000,1'b1,2}, '{4'b0010,4'b0000,1'b1,1}, '{4'b0010,4'b0000,1'b1,0},
           '{4'b0000,4'b0010,1'b0,0}, '{4'b0000,4'b0000,1'b0,0}, '{4'b0000,4'b0000,1'b0,0},
           '{4'b0000,4'b0000,1'b0,0}, '{4'b0010,4'b0000,1'b1,5}, '{4'b0000,4'b0000,1'b0,0},
           '{4'b0000,4'b0000,1'b0,0}};
    bus.req = 4'b0010; bus.delay[1] = DW'(5);
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++;
      if ({bus.grant, bus.done, bus.busy} !== {ex[c].g, ex[c].d, ex[c].b} || bus.remaining !== DW'(ex[c].r)) begin
        errors++;
        $display("FAIL pause c%0d: got g=%b d=%b b=%b r=%0d want g=%b d=%b b=%b r=%0d", c,
                 bus.grant, bus.done, bus.busy, bus.remaining, ex[c].g, ex[c].d, ex[c].b, ex[c].r);
      end
      if (c == 2 || c == 9) bus.pause = 1'b1;
      if (c == 5 || c == 12) bus.pause = 1'b0;
      if (c == 13) begin bus.req = '0; bus.pause = 1'b1; end
      if (c == 14) bus.pause = 1'b0;
    end
  endtask

  task automatic test_abort();
    exp_t ex[10];
    ex = '{'{4'b0001,4'b0000,1'b1,10}, '{4'b0001,4'b0000,1'b1,9}, '{4'b0001,4'b0000,1'b1,8},
           '{4'b0001,4'b0000,1'b1,7},  '{4'b0001,4'b0000,1'b1,6}, '{4'b0001,4'b0000,1'b1,5},
           '{4'b0001,4'b0000,1'b1,4},  '{4'b0000,4'b0000,1'b0,0}, '{4'b1000,4'b0000,1'b1,2},
           '{4'b0000,4'b0000,1'b0,0}};
    bus.req = 4'b0001; bus.delay[0] = DW'(10); bus.delay[3] = DW'(2);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({bus.grant, bus.done, bus.busy} !== {ex[c].g, ex[c].d, ex[c].b} || bus.remaining !== DW'(ex[c].r)) begin
        errors++;
        $display("FAIL abort c%0d: got g=%b d=%b b=%b r=%0d want g=%b d=%b b=%b r=%0d", c,
                 bus.grant, bus.done, bus.busy, bus.remaining, ex[c].g, ex[c].d, ex[c].b, ex[c].r);
      end
      if (c == 6) bus.req = 4'b1000;
      if (c == 8) bus.req = '0;
    end
  endtask

  task automatic test_reset_mid_count();
    exp_t ex[7];
    ex = '{'{4'b0001,4'b0000,1'b1,8}, '{4'b0001,4'b0000,1'b1,7}, '{4'b0001,4'b0000,1'b1,6},
           '{4'b0001,4'b0000,1'b1,5}, '{4'b0000,4'b0000,1'b0,0}, '{4'b0000,4'b0000,1'b0,0},
           '{4'b0000,4'b0000,1'b0,0}};
    bus.req = 4'b0001; bus.delay[0] = DW'(8);
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if ({bus.grant, bus.done, bus.busy} !== {ex[c].g, ex[c].d, ex[c].b} || bus.remaining !== DW'(ex[c].r)) begin
        errors++;
        $display("FAIL reset_mid c%0d: got g=%b d=%b b=%b r=%0d want g=%b d=%b b=%b r=%0d", c,
                 bus.grant, bus.done, bus.busy, bus.remaining, ex[c].g, ex[c].d, ex[c].b, ex[c].r);
      end
      if (c == 3) reset = 1'b1;
      if (c == 4) begin reset = 1'b0; bus.req = '0; end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_delay();
    test_round_robin();
    test_pause();
    test_abort();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
